conv1_feed_ctrl: RTL and testbench



---
 rtl/conv1_feed_ctrl_if.sv | 30 +++
 rtl/conv1_feed_ctrl.sv | 147 ++++++++++++++
 tb/tb_conv1_feed_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_feed_ctrl_if.sv
// Frame-memory read port and window-buffer pixel/window strobes shared by
// the conv1 feed controller (master) and the memory/buffer side (slave).
interface conv1_feed_ctrl_if #(
  parameter int A_BITS = 10
) ();
  logic              mem_en;
  logic [A_BITS-1:0] mem_addr;
  logic              mem_data;
  logic              buf_valid_in;
  logic              buf_pixel_in;
  logic              buf_valid_out;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_data,
    output buf_valid_in,
    output buf_pixel_in,
    input  buf_valid_out
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_data,
    input  buf_valid_in,
    input  buf_pixel_in,
    output buf_valid_out
  );
endinterface

// File: rtl/conv1_feed_ctrl.sv
// conv1 feed controller: streams one binarized WIDTH x HEIGHT frame from a
// 1-bit synchronous-read memory into the 3x3 window buffer in raster order,
// counts the windows the buffer produces and reports done / drain timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; window strobes ignored
// STREAM | issuing one memory read per unstalled cycle, addr 0..NPIX-1
// DRAIN  | all reads issued; waiting for the last windows or the timeout
// DONE   | one-cycle done pulse, then back to IDLE
module conv1_feed_ctrl #(
  parameter  int WIDTH         = 28,
  parameter  int HEIGHT        = 28,
  parameter  int DRAIN_TIMEOUT = 16,
  localparam int NPIX          = WIDTH * HEIGHT,
  localparam int NWIN          = (WIDTH - 2) * (HEIGHT - 2),
  localparam int A_BITS        = $clog2(NPIX),
  localparam int W_BITS        = $clog2(NWIN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  conv1_feed_ctrl_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [W_BITS-1:0]     win_cnt
);

  localparam int T_BITS = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [A_BITS-1:0] addr;
  logic [W_BITS-1:0] win_q;
  logic [T_BITS-1:0] tcnt;
  logic              rd_pend;
  logic              err_q;
  logic              busy_q;
  logic              done_q;

  logic              issue;
  logic              last_issue;
  logic              win_inc;
  logic [W_BITS-1:0] win_next;
  logic              win_full_next;
  logic              timeout_hit;

  // Issue/count decode: stall gates only new reads, never the data return.
  always_comb begin
    issue         = 1'b0;
    last_issue    = 1'b0;
    win_inc       = 1'b0;
    win_next      = win_q;
    win_full_next = 1'b0;
    timeout_hit   = 1'b0;
    issue      = (state == S_STREAM) && !stall;
    last_issue = issue && (addr == A_BITS'(NPIX - 1));
    // Windows beyond NWIN are dropped silently (saturation).
    win_inc    = ((state == S_STREAM) || (state == S_DRAIN)) &&
                 bus.buf_valid_out && (win_q != W_BITS'(NWIN));
    if (win_inc) begin
      win_next = win_q + W_BITS'(1);
    end
    win_full_next = (win_next == W_BITS'(NWIN));
    timeout_hit   = (tcnt == T_BITS'(DRAIN_TIMEOUT - 1));
  end

  // Sequencer: state, read address, window/timeout counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      win_q   <= '0;
      tcnt    <= '0;
      rd_pend <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_pend <= issue;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_STREAM;
            addr   <= '0;
            win_q  <= '0;
            tcnt   <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        S_STREAM: begin
          win_q <= win_next;
          if (issue) begin
            addr <= addr + A_BITS'(1);
          end
          if (last_issue) begin
            state <= S_DRAIN;
            tcnt  <= '0;
          end
        end
        S_DRAIN: begin
          win_q <= win_next;
          tcnt  <= tcnt + T_BITS'(1);
          // Window completion wins over a simultaneous timeout.
          if (win_full_next) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else if (timeout_hit) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // start is not looked at here; it must be seen again in IDLE.
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en       = issue;
  assign bus.mem_addr     = issue ? addr : '0;
  assign bus.buf_valid_in = rd_pend;
  // Gated so the pixel line is quiet whenever no read is returning.
  assign bus.buf_pixel_in = rd_pend & bus.mem_data;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign win_cnt          = win_q;

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Self-checking bench for conv1_feed_ctrl: frame memory model, a 2-cycle
// window-buffer stub, table-driven frames and hand-written corner sequences.
module tb_conv1_feed_ctrl;
  localparam int WIDTH  = 28;
  localparam int HEIGHT = 28;
  localparam int DT     = 16;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NWIN   = (WIDTH - 2) * (HEIGHT - 2);
  localparam int A_BITS = $clog2(NPIX);
  localparam int W_BITS = $clog2(NWIN + 1);
  localparam int MAXC   = 3 * NPIX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic busy, done, err;
  logic [W_BITS-1:0] win_cnt;

  int checks = 0;
  int failures = 0;

  logic img [NPIX];
  logic stall_pat [MAXC + 2];
  bit   buf_on = 1'b1;
  logic mem_q = 1'b0;
  int   bpix;
  logic v1, v2;

  conv1_feed_ctrl_if #(.A_BITS(A_BITS)) bus ();

  conv1_feed_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .bus(bus),
    .busy(busy), .done(done), .err(err), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  // frame memory, 1-cycle synchronous read
  always @(posedge clk) if (bus.mem_en) mem_q <= img[bus.mem_addr];
  assign bus.mem_data = mem_q;

  // window buffer stub: window for pixel (r>=2, c>=2) appears 2 cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bpix <= 0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      v2 <= v1;
      v1 <= 1'b0;
      if (bus.buf_valid_in) begin
        v1   <= ((bpix / WIDTH) >= 2) && ((bpix % WIDTH) >= 2);
        bpix <= (bpix == NPIX - 1) ? 0 : bpix + 1;
      end
    end
  end
  assign bus.buf_valid_out = buf_on & v2;

  typedef struct {
    int img_kind;
    int stall_kind;
    bit buf_conn;
    int exp_win;
    bit exp_err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_img(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0: img[i] = 1'b1;
        1: img[i] = logic'(((i / WIDTH) + (i % WIDTH)) % 2);
        2: img[i] = logic'($urandom_range(0, 1));
        default: img[i] = 1'b0;
      endcase
    end
  endtask

  task automatic fill_stall(input int kind);
    for (int k = 0; k <= MAXC + 1; k++) begin
      case (kind)
        0: stall_pat[k] = 1'b0;
        1: stall_pat[k] = ((k >= 100) && (k <= 109)) || ((k > 109) && (k % 7 == 0));
        2: stall_pat[k] = (k % 2 == 0);
        default: stall_pat[k] = ($urandom_range(0, 3) == 0);
      endcase
    end
    stall_pat[0] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_en"}, int'(bus.mem_en), 0);
    chk({tag, ".mem_addr"}, int'(bus.mem_addr), 0);
    chk({tag, ".valid_in"}, int'(bus.buf_valid_in), 0);
    chk({tag, ".pixel_in"}, int'(bus.buf_pixel_in), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".err"}, int'(err), 0);
    chk({tag, ".win_cnt"}, int'(win_cnt), 0);
  endtask

  // One frame: reference timing derived from the stall pattern alone.
  task automatic run_frame(input string tag, input bit conn, input int exp_win, input bit exp_err);
    int exp_cyc [NPIX];
    int n = 0;
    int exp_done;
    int n_iss = 0, iss_bad = 0, n_pix = 0, pix_bad = 0;
    int n_done = 0, done_cyc = -1, n_busy = 0;
    int win_at_done = -1, err_at_done = -1, err_c1 = -1;
    for (int k = 1; k <= MAXC && n < NPIX; k++) begin
      if (!stall_pat[k]) begin
        exp_cyc[n] = k;
        n++;
      end
    end
    exp_done = conn ? exp_cyc[NPIX-1] + 4 : exp_cyc[NPIX-1] + 1 + DT;
    buf_on = conn;
    @(posedge clk); #1; start = 1'b1; stall = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= MAXC; k++) begin
      #1; start = 1'b0; stall = stall_pat[k];
      @(negedge clk);
      if (bus.mem_en) begin
        if (n_iss >= NPIX) iss_bad++;
        else if (int'(bus.mem_addr) != n_iss || k != exp_cyc[n_iss]) iss_bad++;
        n_iss++;
      end
      if (bus.buf_valid_in) begin
        if (n_pix >= NPIX) pix_bad++;
        else if (bus.buf_pixel_in !== img[n_pix] || k != exp_cyc[n_pix] + 1) pix_bad++;
        n_pix++;
      end
      if (busy) n_busy++;
      if (k == 1) err_c1 = int'(err);
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k; win_at_done = int'(win_cnt); err_at_done = int'(err);
        end
      end
      @(posedge clk);
      if (done_cyc > 0 && k >= done_cyc + 2) break;
    end
    stall = 1'b0;
    chk({tag, ".issue_cnt"}, n_iss, NPIX);
    chk({tag, ".issue_order"}, iss_bad, 0);
    chk({tag, ".valid_in_cnt"}, n_pix, NPIX);
    chk({tag, ".pixel_seq"}, pix_bad, 0);
    chk({tag, ".done_cycle"}, done_cyc, exp_done);
    chk({tag, ".done_pulses"}, n_done, 1);
    chk({tag, ".win_cnt"}, win_at_done, exp_win);
    chk({tag, ".err"}, err_at_done, int'(exp_err));
    chk({tag, ".busy_cycles"}, n_busy, exp_done);
    chk({tag, ".err_cleared"}, err_c1, 0);
  endtask

  initial begin
    int found;
    int d1, d2, w1, w2, busy_gap, restart_ok;

    vecs[0] = '{0, 0, 1'b1, NWIN, 1'b0};
    vecs[1] = '{0, 1, 1'b1, NWIN, 1'b0};
    vecs[2] = '{1, 2, 1'b1, NWIN, 1'b0};
    vecs[3] = '{2, 3, 1'b1, NWIN, 1'b0};
    vecs[4] = '{2, 0, 1'b0, 0,    1'b1};
    vecs[5] = '{3, 3, 1'b1, NWIN, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_img(vecs[i].img_kind);
      fill_stall(vecs[i].stall_kind);
      run_frame($sformatf("vec%0d", i), vecs[i].buf_conn, vecs[i].exp_win, vecs[i].exp_err);
    end

    // reset in the middle of STREAM at address 300
    fill_img(2);
    fill_stall(0);
    buf_on = 1'b1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.mem_en && int'(bus.mem_addr) == 300) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid.reach300", found, 1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk); rst = 1'b0;
    run_frame("after_rst", 1'b1, NWIN, 1'b0);

    // start held high across two frames
    fill_img(0);
    fill_stall(0);
    buf_on = 1'b1;
    d1 = -1; d2 = -1; w1 = -1; w2 = -1; busy_gap = -1; restart_ok = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 2 * NPIX + 40; k++) begin
      @(negedge clk);
      if (d1 > 0 && k == d1 + 1) busy_gap = int'(busy) + int'(bus.mem_en);
      if (d1 > 0 && k == d1 + 2) restart_ok = int'(bus.mem_en && bus.mem_addr == '0);
      if (done) begin
        if (d1 < 0) begin
          d1 = k; w1 = int'(win_cnt);
        end else begin
          d2 = k; w2 = int'(win_cnt);
          start = 1'b0;
          break;
        end
      end
      @(posedge clk);
    end
    start = 1'b0;
    chk("hold.done1_cycle", d1, NPIX + 4);
    chk("hold.idle_gap", busy_gap, 0);
    chk("hold.restart_addr0", restart_ok, 1);
    chk("hold.done2_cycle", d2, 2 * (NPIX + 4) + 1);
    chk("hold.win1", w1, NWIN);
    chk("hold.win2", w2, NWIN);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
